collect_data_9: RTL and testbench
=================================

# collect_data_9

Receive-side monitor for the 9-router test network, the counterpart of the data injector. It watches the nine router output packets and detects each new arrival on the valid-bit rising edge. Arrivals are queued in arrival order, lowest router index first when several arrive at once. The head arrival, meaning which router delivered it and its two 4-bit step fields, is shown on active-low 7-segment displays, with a push-key to step through the queue.

## Interface
- N2, 9, packet width: bit 8 valid, bits 7:4 step1, bits 3:0 step2
- ROUTERS, 9, number of monitored router outputs
- DEPTH, 4, arrival queue depth (power of two)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- in_router1 … in_router9  in  N2 each  router output packets
- sw_clear  in  1  level; while 1, synchronous clear of queue, pending, count, overflow
- key_next  in  1  level; a rising edge pops the head entry
- hex_router  out  7  head router index 0–8, active-low
- hex_step1, hex_step2  out  7 each  head data nibbles, active-low
- hex_count  out  7  arrival count, active-low
- led_empty  out  1  queue empty
- led_overflow  out  1  sticky: an arrival was dropped

## Operation
- **Arrival detection.**
  - Per router: prev_valid[i] register and data_lat[i] (8 b).
  - At each edge, if in_router(i)[8]=1 and prev_valid[i]=0, then pending[i] is set and data_lat[i] captures in_router(i)[7:0].
  - prev_valid[i] is updated every edge.
  - A held packet produces exactly one arrival.
- **Queue write.**
  - Each edge, if pending≠0, the lowest set index j is selected and pending[j] is cleared.
  - If the queue is not full, {j[3:0], data_lat[j]} is written. If it is full, the entry is dropped and led_overflow is set.
  - arrival count (4 b, wraps 15→0) increments on every selection, whether written or dropped.
- **Pop.**
  - Rising edge of key_next, detected using a key flag register: if the queue is not empty, the head is advanced.
  - Ignored when the queue is empty.
  - Pop and write in the same cycle are both performed, including when full: the write succeeds and no overflow occurs.
- **Display encoding.**
  - Digits 0–9 use patterns ~1111110, ~0110000, ~1101101, ~1111001, ~0110011, ~1011011, ~1011111, ~1110000, ~1111111, ~1111011.
  - Values 10–15 show dash ~0000001.
  - An empty queue shows dash on hex_router, hex_step1 and hex_step2.
- **Reset.** rst (or sw_clear) clears pending, the queue, the count, led_overflow and the key flag. rst also clears prev_valid; sw_clear does not. As a result, a packet held valid through reset is counted once after reset, but is not re-counted after sw_clear.

## Timing
- Reset values:
  - hex_router, hex_step1, hex_step2 = 7'b1111110 (dash)
  - hex_count = 7'b0000001 ('0')
  - led_empty = 1, led_overflow = 0
- Latency:
  - Valid rise sampled at edge k sets pending at k.
  - Queue write and count increment happen at edge k+1.
  - Hex and LED outputs are registered and reflect queue state at edge k+2.
- Throughput: one queue write per cycle. n simultaneous arrivals drain over n cycles in ascending index order.
- Pop: a key_next rise sampled at edge k makes the head advance at k; the display updates at k+1. Holding the key pops only once.
- sw_clear dominates write and pop in the same cycle. rst dominates everything.
- New valid rises during sw_clear=1 are discarded, but prev_valid still tracks.

## Structure
- Shared package `noc_pkg`:
  - N2, ROUTERS constants
  - 7-segment digit constants
  - SEG_DASH
  - function seg7(4-bit) → 7-bit active-low
- Sub-module `arrival_fifo`: parameterised DEPTH × 12 b synchronous FIFO.
  - Ports: wr_en, din, rd_en, dout, empty, full, clr.
  - Behaviour: simultaneous read+write when full is allowed; clr is a synchronous clear.
- Top module: edge detection, pending priority select, count, key edge detect, display registers.

## Test plan
- Reset, then in_router3 = 9'b1_0010_0101 held 10 cycles → at edge k+2, hex_router='2', hex_step1='2', hex_step2='5', hex_count='1', led_empty=0. No second arrival.
- in_router1, in_router5 and in_router9 rise on the same edge with data 0x11, 0x22, 0x33 → queue holds routers 0, 4, 8 in order. Three key_next presses display 0, 4, 8, then dashes and led_empty=1.
- Six distinct rises without popping → four entries queued, led_overflow=1, hex_count='6'. The head is still the first arrival.
- Queue full, and a key_next rise coincides with a write → the pop and the write both succeed, and led_overflow stays 0.
- Packet held high, then sw_clear pulsed → count returns to '0', queue is empty, and there is no re-arrival. After a subsequent rst with the packet still held → exactly one arrival.
- Twelve arrivals with a pop after each → hex_count shows '9' at 9 arrivals, dash at 10–11. Count wrap at 16 is verified separately.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared constants, arrival entry layout and 7-segment encoder
// for the 9-router test network monitor.
package noc_pkg;

  localparam int N2      = 9;
  localparam int ROUTERS = 9;

  localparam logic [6:0] SEG_0    = ~7'b1111110;
  localparam logic [6:0] SEG_1    = ~7'b0110000;
  localparam logic [6:0] SEG_2    = ~7'b1101101;
  localparam logic [6:0] SEG_3    = ~7'b1111001;
  localparam logic [6:0] SEG_4    = ~7'b0110011;
  localparam logic [6:0] SEG_5    = ~7'b1011011;
  localparam logic [6:0] SEG_6    = ~7'b1011111;
  localparam logic [6:0] SEG_7    = ~7'b1110000;
  localparam logic [6:0] SEG_8    = ~7'b1111111;
  localparam logic [6:0] SEG_9    = ~7'b1111011;
  localparam logic [6:0] SEG_DASH = ~7'b0000001;

  typedef struct packed {
    logic [3:0] router;
    logic [3:0] step1;
    logic [3:0] step2;
  } arrival_t;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/arrival_fifo.sv
// Synchronous FIFO of arrival entries; a read frees a slot
// for a write in the same cycle even when full.
module arrival_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_rd, do_wr;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/collect_data_9.sv
// Receive-side monitor: valid-edge arrival detection, ordered
// queueing and 7-segment display of the head arrival.
module collect_data_9
  import noc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N2-1:0] in_router1,
  input  logic [N2-1:0] in_router2,
  input  logic [N2-1:0] in_router3,
  input  logic [N2-1:0] in_router4,
  input  logic [N2-1:0] in_router5,
  input  logic [N2-1:0] in_router6,
  input  logic [N2-1:0] in_router7,
  input  logic [N2-1:0] in_router8,
  input  logic [N2-1:0] in_router9,
  input  logic          sw_clear,
  input  logic          key_next,
  output logic [6:0]    hex_router,
  output logic [6:0]    hex_step1,
  output logic [6:0]    hex_step2,
  output logic [6:0]    hex_count,
  output logic          led_empty,
  output logic          led_overflow
);

  logic [N2-1:0]      in_r [ROUTERS];
  logic [ROUTERS-1:0] valid_v, rise;
  logic [ROUTERS-1:0] prev_valid_q, prev_valid_d;
  logic [ROUTERS-1:0] pending_q, pending_d;
  logic [ROUTERS-1:0] sel_oh;
  logic [7:0]         data_lat_q [ROUTERS];
  logic [7:0]         data_lat_d [ROUTERS];
  logic [3:0]         sel_idx;
  logic [7:0]         sel_data;
  logic               sel_any, clr;
  logic [3:0]         count_q, count_d;
  logic               key_q, key_d, pop;
  logic               ovf_q, ovf_d;
  logic               wr_en, f_empty, f_full;
  arrival_t           f_dout, f_din;
  logic [6:0]         hex_router_q, hex_router_d;
  logic [6:0]         hex_step1_q, hex_step1_d;
  logic [6:0]         hex_step2_q, hex_step2_d;
  logic [6:0]         hex_count_q, hex_count_d;
  logic               led_empty_q, led_empty_d;
  logic               led_ovf_q, led_ovf_d;

  assign in_r[0] = in_router1;
  assign in_r[1] = in_router2;
  assign in_r[2] = in_router3;
  assign in_r[3] = in_router4;
  assign in_r[4] = in_router5;
  assign in_r[5] = in_router6;
  assign in_r[6] = in_router7;
  assign in_r[7] = in_router8;
  assign in_r[8] = in_router9;

  assign clr = rst | sw_clear;

  always_comb begin
    for (int i = 0; i < ROUTERS; i++) begin
      valid_v[i] = in_r[i][8];
    end
  end

  assign rise    = valid_v & ~prev_valid_q;
  assign sel_any = |pending_q;
  assign sel_oh  = pending_q & (~pending_q + 1'b1);

  // Descending scan so the lowest pending index wins.
  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int i = ROUTERS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx  = 4'(i);
        sel_data = data_lat_q[i];
      end
    end
  end

  assign wr_en = sel_any & ~clr;
  assign pop   = key_next & ~key_q & ~clr;
  assign f_din = '{router: sel_idx,
                   step1:  sel_data[7:4],
                   step2:  sel_data[3:0]};

  always_comb begin
    prev_valid_d = rst ? '0 : valid_v;
    pending_d    = clr ? '0 : ((pending_q & ~sel_oh) | rise);
    for (int i = 0; i < ROUTERS; i++) begin
      data_lat_d[i] = data_lat_q[i];
      if (rise[i] && !clr) data_lat_d[i] = in_r[i][7:0];
    end
    count_d = clr ? 4'd0 : count_q + {3'd0, sel_any};
    key_d   = clr ? 1'b0 : key_next;
    // A pop in the same cycle makes room, so no drop then.
    ovf_d   = clr ? 1'b0 :
              (ovf_q | (wr_en & f_full & ~(pop & ~f_empty)));
  end

  always_comb begin
    led_empty_d = f_empty;
    led_ovf_d   = ovf_q;
    hex_count_d = seg7(count_q);
    if (f_empty) begin
      hex_router_d = SEG_DASH;
      hex_step1_d  = SEG_DASH;
      hex_step2_d  = SEG_DASH;
    end else begin
      hex_router_d = seg7(f_dout.router);
      hex_step1_d  = seg7(f_dout.step1);
      hex_step2_d  = seg7(f_dout.step2);
    end
  end

  always_ff @(posedge clk) begin
    prev_valid_q <= prev_valid_d;
    pending_q    <= pending_d;
    count_q      <= count_d;
    key_q        <= key_d;
    ovf_q        <= ovf_d;
    for (int i = 0; i < ROUTERS; i++) begin
      data_lat_q[i] <= rst ? 8'd0 : data_lat_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hex_router_q <= SEG_DASH;
      hex_step1_q  <= SEG_DASH;
      hex_step2_q  <= SEG_DASH;
      hex_count_q  <= SEG_0;
      led_empty_q  <= 1'b1;
      led_ovf_q    <= 1'b0;
    end else begin
      hex_router_q <= hex_router_d;
      hex_step1_q  <= hex_step1_d;
      hex_step2_q  <= hex_step2_d;
      hex_count_q  <= hex_count_d;
      led_empty_q  <= led_empty_d;
      led_ovf_q    <= led_ovf_d;
    end
  end

  arrival_fifo #(.DEPTH(DEPTH), .W(12)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .wr_en (wr_en),
    .din   (f_din),
    .rd_en (pop),
    .dout  (f_dout),
    .empty (f_empty),
    .full  (f_full)
  );

  assign hex_router   = hex_router_q;
  assign hex_step1    = hex_step1_q;
  assign hex_step2    = hex_step2_q;
  assign hex_count    = hex_count_q;
  assign led_empty    = led_empty_q;
  assign led_overflow = led_ovf_q;

endmodule

// File: tb/tb_collect_data_9.sv
// Directed bench for collect_data_9: arrival order, overflow,
// pop/write overlap, clear vs reset and count display.
module tb_collect_data_9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] r [1:9];
  logic       sw_clear = 1'b0;
  logic       key_next = 1'b0;
  logic [6:0] hex_router, hex_step1, hex_step2, hex_count;
  logic       led_empty, led_overflow;
  int         checks = 0;
  int         failures = 0;

  localparam logic [6:0] DASH = ~7'b0000001;

  always #5 clk = ~clk;

  collect_data_9 dut (
    .clk          (clk),
    .rst          (rst),
    .in_router1   (r[1]),
    .in_router2   (r[2]),
    .in_router3   (r[3]),
    .in_router4   (r[4]),
    .in_router5   (r[5]),
    .in_router6   (r[6]),
    .in_router7   (r[7]),
    .in_router8   (r[8]),
    .in_router9   (r[9]),
    .sw_clear     (sw_clear),
    .key_next     (key_next),
    .hex_router   (hex_router),
    .hex_step1    (hex_step1),
    .hex_step2    (hex_step2),
    .hex_count    (hex_count),
    .led_empty    (led_empty),
    .led_overflow (led_overflow)
  );

  function automatic logic [6:0] ex_seg(input int v);
    case (v)
      0: return ~7'b1111110;
      1: return ~7'b0110000;
      2: return ~7'b1101101;
      3: return ~7'b1111001;
      4: return ~7'b0110011;
      5: return ~7'b1011011;
      6: return ~7'b1011111;
      7: return ~7'b1110000;
      8: return ~7'b1111111;
      9: return ~7'b1111011;
      default: return ~7'b0000001;
    endcase
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] obs,
                     input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic press();
    key_next = 1'b1;
    tick();
    key_next = 1'b0;
    tick();
  endtask

  task automatic head(input string tag, input int rt,
                      input int s1, input int s2);
    chk({tag, "_router"}, hex_router, ex_seg(rt));
    chk({tag, "_step1"}, hex_step1, ex_seg(s1));
    chk({tag, "_step2"}, hex_step2, ex_seg(s2));
  endtask

  initial begin
    for (int i = 1; i <= 9; i++) r[i] = 9'd0;
    tick(2);
    chk("rst_router", hex_router, DASH);
    chk("rst_step1", hex_step1, DASH);
    chk("rst_step2", hex_step2, DASH);
    chk("rst_count", hex_count, 7'b0000001);
    chk("rst_empty", {6'd0, led_empty}, 7'd1);
    chk("rst_ovf", {6'd0, led_overflow}, 7'd0);
    rst = 1'b0;
    tick();

    // single held packet
    r[3] = 9'b1_0010_0101;
    tick(3);
    head("one", 2, 2, 5);
    chk("one_count", hex_count, ex_seg(1));
    chk("one_empty", {6'd0, led_empty}, 7'd0);
    tick(10);
    chk("one_held", hex_count, ex_seg(1));
    press();
    chk("one_pop", hex_router, DASH);
    chk("one_pop_empty", {6'd0, led_empty}, 7'd1);
    r[3] = 9'd0;
    tick();

    // simultaneous arrivals drain lowest index first
    r[1] = 9'h111;
    r[5] = 9'h122;
    r[9] = 9'h133;
    tick(5);
    head("sim0", 0, 1, 1);
    chk("sim_count", hex_count, ex_seg(4));
    press();
    head("sim4", 4, 2, 2);
    press();
    head("sim8", 8, 3, 3);
    press();
    head("sim_end", 15, 15, 15);
    chk("sim_empty", {6'd0, led_empty}, 7'd1);
    r[1] = 9'd0;
    r[5] = 9'd0;
    r[9] = 9'd0;
    tick();

    // overflow: six arrivals into a four-deep queue
    sw_clear = 1'b1;
    tick();
    sw_clear = 1'b0;
    tick();
    chk("clr_count", hex_count, ex_seg(0));
    for (int i = 1; i <= 6; i++) r[i] = {1'b1, 4'(i), 4'(i)};
    tick(8);
    chk("ovf_led", {6'd0, led_overflow}, 7'd1);
    chk("ovf_count", hex_count, ex_seg(6));
    head("ovf_head", 0, 1, 1);

    // pop and write on the same edge while full
    sw_clear = 1'b1;
    tick();
    sw_clear = 1'b0;
    for (int i = 1; i <= 9; i++) r[i] = 9'd0;
    tick();
    for (int i = 1; i <= 4; i++) r[i] = {1'b1, 4'(i), 4'(i)};
    tick(6);
    chk("full_count", hex_count, ex_seg(4));
    chk("full_ovf", {6'd0, led_overflow}, 7'd0);
    r[7] = 9'h177;
    tick();
    key_next = 1'b1;
    tick();
    key_next = 1'b0;
    tick();
    head("pw_head", 1, 2, 2);
    chk("pw_count", hex_count, ex_seg(5));
    chk("pw_ovf", {6'd0, led_overflow}, 7'd0);
    press();
    press();
    press();
    head("pw_last", 6, 7, 7);
    press();
    chk("pw_empty", {6'd0, led_empty}, 7'd1);

    // sw_clear with packets held: no re-arrival
    sw_clear = 1'b1;
    tick();
    sw_clear = 1'b0;
    tick(3);
    chk("swc_count", hex_count, ex_seg(0));
    chk("swc_empty", {6'd0, led_empty}, 7'd1);
    chk("swc_router", hex_router, DASH);
    tick(4);
    chk("swc_norearr", hex_count, ex_seg(0));

    // rst with one packet held: counted exactly once
    for (int i = 1; i <= 9; i++) if (i != 3) r[i] = 9'd0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(3);
    chk("rst_held_count", hex_count, ex_seg(1));
    head("rst_held", 2, 3, 3);
    tick(5);
    chk("rst_held_once", hex_count, ex_seg(1));

    // count display and wrap
    r[3] = 9'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("cnt_start", hex_count, ex_seg(0));
    for (int n = 1; n <= 16; n++) begin
      r[1] = 9'h111;
      tick();
      r[1] = 9'd0;
      tick(2);
      chk($sformatf("cnt_%0d", n), hex_count, ex_seg(n % 16));
      press();
    end
    chk("cnt_ovf", {6'd0, led_overflow}, 7'd0);
    chk("cnt_empty", {6'd0, led_empty}, 7'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
